// File: rtl/dsc_pkg.sv
// Shared types and width helpers for the dsc stochastic-number datapath blocks.
package dsc_pkg;

    // Decoder control states
    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    localparam int unsigned DefaultLenLog2 = 4;

    // Result width: must hold the all-ones count 2^len_log2
    function automatic int unsigned count_width(input int unsigned len_log2);
        return len_log2 + 1;
    endfunction

    // Number of accepted bits per window
    function automatic int unsigned window_len(input int unsigned len_log2);
        return 32'd1 << len_log2;
    endfunction

endpackage

// File: rtl/sn_window_ctr.sv
// Window position counter: counts accepted bits, flags the last position of the window.
module sn_window_ctr #(
    parameter int unsigned LEN_LOG2 = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic term
);

    logic [LEN_LOG2-1:0] cnt_q, cnt_d;

    // Clear has priority; the counter wraps naturally after the last position
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + LEN_LOG2'(1);
        end
    end

    // Position register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal position 2^LEN_LOG2-1
    always_comb begin
        term = (cnt_q == '1);
    end

endmodule

// File: rtl/sn_stream_decoder.sv
// Serial stochastic-number decoder: counts ones over a 2^LEN_LOG2-bit window and
// returns the count through a valid/ready handshake.
// Optional build macro DSC_EARLY_TERM_EN: an accepted zero closes the window early
// (unary, ones-first streams).
module sn_stream_decoder
    import dsc_pkg::*;
#(
    parameter int unsigned LEN_LOG2 = DefaultLenLog2,
    parameter int unsigned COUNT_W  = count_width(LEN_LOG2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sn_in,
    input  logic               sn_valid,
    output logic               sn_ready,
    output logic [COUNT_W-1:0] bin_out,
    output logic               bin_valid,
    input  logic               bin_ready,
    output logic               done
);

    state_e state_q, state_d;

    logic               accept;
    logic               close;
    logic               handshake;
    logic               ctr_clr;
    logic               ctr_inc;
    logic               ctr_term;
    logic [COUNT_W-1:0] one_cnt_q, one_cnt_d;
    logic [COUNT_W-1:0] bin_out_q, bin_out_d;
    logic               bin_valid_q, bin_valid_d;
    logic               done_q, done_d;

    sn_window_ctr #(
        .LEN_LOG2(LEN_LOG2)
    ) u_window_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (ctr_clr),
        .inc  (ctr_inc),
        .term (ctr_term)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (close) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (handshake) begin
                    state_d = en ? StAccum : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs and window control strobes
    always_comb begin
        sn_ready  = (state_q == StAccum) & en;
        accept    = sn_ready & sn_valid;
        handshake = bin_valid_q & bin_ready;
        ctr_clr   = ((state_q == StIdle) & en) | ((state_q == StHold) & handshake);
`ifdef DSC_EARLY_TERM_EN
        // A zero ends a unary stream; the position counter stops there
        close     = accept & (ctr_term | ~sn_in);
        ctr_inc   = accept & sn_in;
`else
        close     = accept & ctr_term;
        ctr_inc   = accept;
`endif
    end

    // Ones count, result register, valid and done pulse next-state
    always_comb begin
        one_cnt_d   = one_cnt_q;
        bin_out_d   = bin_out_q;
        bin_valid_d = bin_valid_q;
        done_d      = close;
        if (ctr_clr) begin
            one_cnt_d = '0;
        end else if (accept & sn_in) begin
            one_cnt_d = one_cnt_q + COUNT_W'(1);
        end
        if (close) begin
            // The closing bit is folded in directly rather than via one_cnt
            bin_out_d   = one_cnt_q + COUNT_W'(sn_in);
            bin_valid_d = 1'b1;
        end else if (handshake) begin
            bin_valid_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            one_cnt_q   <= '0;
            bin_out_q   <= '0;
            bin_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            one_cnt_q   <= one_cnt_d;
            bin_out_q   <= bin_out_d;
            bin_valid_q <= bin_valid_d;
            done_q      <= done_d;
        end
    end

    // Registered outputs
    always_comb begin
        bin_out   = bin_out_q;
        bin_valid = bin_valid_q;
        done      = done_q;
    end

endmodule

// File: tb/tb_sn_stream_decoder.sv
// Randomized scoreboard bench for sn_stream_decoder (LEN_LOG2=4).
module tb_sn_stream_decoder;

    localparam int unsigned LenLog2 = 4;
    localparam int unsigned CountW  = LenLog2 + 1;
    localparam int          Win     = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              sn_in;
    logic              sn_valid;
    logic              sn_ready;
    logic [CountW-1:0] bin_out;
    logic              bin_valid;
    logic              bin_ready;
    logic              done;

    sn_stream_decoder #(
        .LEN_LOG2(LenLog2),
        .COUNT_W (CountW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sn_in     (sn_in),
        .sn_valid  (sn_valid),
        .sn_ready  (sn_ready),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .bin_ready (bin_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    // Reference model: window progress as plain counters
    bit m_active;
    bit m_hold;
    int m_bits;
    int m_ones;
    int m_hold_val;
    bit m_done_now;
    bit did_reset;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        m_active   = 1'b0;
        m_hold     = 1'b0;
        m_bits     = 0;
        m_ones     = 0;
        m_hold_val = 0;
        m_done_now = 1'b0;
    endtask

    task automatic drive(input int mode);
        case (mode)
            0: begin  // alternating 1/0 by window position
                en = 1'b1; sn_valid = 1'b1; sn_in = (m_bits % 2 == 0); bin_ready = 1'b1;
            end
            1: begin
                en = 1'b1; sn_valid = 1'b1; sn_in = 1'b1; bin_ready = 1'b1;
            end
            2: begin
                en = 1'b1; sn_valid = 1'b1; sn_in = 1'b0; bin_ready = 1'b1;
            end
            3: begin  // consumer mostly stalled
                en = 1'b1; sn_valid = 1'b1; sn_in = 1'($urandom % 2);
                bin_ready = ($urandom % 6 == 0);
            end
            4: begin
                en = ($urandom % 10 != 0); sn_valid = 1'($urandom % 2);
                sn_in = 1'($urandom % 2); bin_ready = ($urandom % 10 < 7);
            end
            5: begin
                en = 1'b1; sn_valid = 1'b1; sn_in = 1'b1; bin_ready = 1'b1;
            end
            default: begin
                en = 1'b0; sn_valid = 1'($urandom % 2); sn_in = 1'($urandom % 2);
                bin_ready = 1'b1;
            end
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_sn_ready", sn_ready, 0);
        check("rst_bin_valid", bin_valid, 0);
        check("rst_bin_out", bin_out, 0);
        check("rst_done", done, 0);
        exp_q.delete();
        model_clear();
        en = 1'b0; sn_valid = 1'b0; bin_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Per-cycle checks against the model, then advance the model over the next edge
    task automatic cycle_step();
        bit pred_ready;
        bit closed;
        pred_ready = m_active && !m_hold && en;
        check("sn_ready", sn_ready, pred_ready);
        check("done", done, m_done_now);
        check("bin_valid", bin_valid, m_hold);
        if (m_hold) check("bin_out_held", bin_out, m_hold_val);
        m_done_now = 1'b0;
        if (m_hold) begin
            if (bin_ready) begin
                m_hold   = 1'b0;
                m_bits   = 0;
                m_ones   = 0;
                m_active = en;
            end
        end else if (!m_active) begin
            if (en) begin
                m_active = 1'b1;
                m_bits   = 0;
                m_ones   = 0;
            end
        end else if (pred_ready && sn_valid) begin
            m_bits++;
            m_ones += int'(sn_in);
            closed = (m_bits == Win);
`ifdef DSC_EARLY_TERM_EN
            if (!sn_in) closed = 1'b1;
`endif
            if (closed) begin
                exp_q.push_back(m_ones);
                m_hold_val = m_ones;
                m_hold     = 1'b1;
                m_done_now = 1'b1;
            end
        end
    endtask

    // Monitor: compare every consumed result against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bin_valid && bin_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", int'(bin_out), -1);
                end else begin
                    check("bin_out", bin_out, exp_q.pop_front());
                end
            end
        end
    end

    int seg_len[7]  = '{80, 80, 80, 150, 2000, 40, 30};

    initial begin
        rst = 1'b1; en = 1'b0; sn_in = 1'b0; sn_valid = 1'b0; bin_ready = 1'b0;
        model_clear();
        did_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_sn_ready", sn_ready, 0);
        check("reset_bin_valid", bin_valid, 0);
        check("reset_bin_out", bin_out, 0);
        check("reset_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int seg = 0; seg < 7; seg++) begin
            for (int c = 0; c < seg_len[seg]; c++) begin
                @(posedge clk);
                #1;
                drive(seg);
                if (seg == 5 && !did_reset && m_active && !m_hold && m_bits == 7) begin
                    did_reset = 1'b1;
                    do_reset();
                end else begin
                    @(negedge clk);
                    cycle_step();
                end
            end
        end

        check("reset_mid_window_hit", did_reset, 1);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
